// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: D/E/M/W-stage hazard inputs plus the
// forwarding, stall and flush controls returned to the pipeline.
// master = pipeline side (drives stage info), slave = hazard_ctrl.
interface hazard_ctrl_if;
    logic [4:0]  A1_D;
    logic [4:0]  A2_D;
    logic [1:0]  Tuse_rs_D;
    logic [1:0]  Tuse_rt_D;
    logic        md_D;
    logic        eret_D;
    logic [4:0]  A3_E;
    logic [4:0]  A3_M;
    logic [4:0]  A3_W;
    logic        regWrite_E;
    logic        regWrite_M;
    logic        regWrite_W;
    logic [1:0]  Tnew_E;
    logic [1:0]  Tnew_M;
    logic        mtc0_epc_E;
    logic        mtc0_epc_M;
    logic        start_E;
    logic        div_E;
    logic        req;
    logic [1:0]  RD1_sel;
    logic [1:0]  RD2_sel;
    logic        stall;
    logic        flush_E;
    logic        busy;
    logic [15:0] stall_cnt;

    modport master (
        output A1_D, A2_D, Tuse_rs_D, Tuse_rt_D, md_D, eret_D,
        output A3_E, A3_M, A3_W, regWrite_E, regWrite_M, regWrite_W,
        output Tnew_E, Tnew_M, mtc0_epc_E, mtc0_epc_M,
        output start_E, div_E, req,
        input  RD1_sel, RD2_sel, stall, flush_E, busy, stall_cnt
    );

    modport slave (
        input  A1_D, A2_D, Tuse_rs_D, Tuse_rt_D, md_D, eret_D,
        input  A3_E, A3_M, A3_W, regWrite_E, regWrite_M, regWrite_W,
        input  Tnew_E, Tnew_M, mtc0_epc_E, mtc0_epc_M,
        input  start_E, div_E, req,
        output RD1_sel, RD2_sel, stall, flush_E, busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational D-stage forwarding selects,
// data/MDU/EPC stall generation, exception flush and a multiply/divide
// busy tracker. Optional stall statistics counter enabled by defining
// HAZARD_STALL_STAT_EN; otherwise stall_cnt is tied to zero.
module hazard_ctrl (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;
    localparam logic [1:0] SEL_M      = 2'b10;
    localparam logic [1:0] SEL_W      = 2'b01;
    localparam logic [1:0] SEL_GRF    = 2'b00;
    localparam logic [1:0] TUSE_NONE  = 2'd3;

    logic [3:0] busy_cnt_q;
    logic [3:0] busy_cnt_d;
    logic [1:0] rd1_sel;
    logic [1:0] rd2_sel;
    logic       hazard_rs;
    logic       hazard_rt;
    logic       mdu_busy;
    logic       stall_raw;
    logic       flush_raw;

    // Operand source: M-stage result only once it is actually produced
    // (Tnew_M==0); W always holds a finished value. $0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] addr,
        input logic       rw_m,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m,
        input logic       rw_w,
        input logic [4:0] a3_w
    );
        logic [1:0] sel;
        sel = SEL_GRF;
        if (addr != 5'd0 && rw_m && a3_m == addr && tnew_m == 2'd0) begin
            sel = SEL_M;
        end else if (addr != 5'd0 && rw_w && a3_w == addr) begin
            sel = SEL_W;
        end
        return sel;
    endfunction

    // An operand stalls when a producer in E or M cannot deliver in time.
    // Tuse==3 marks an unused operand and can never stall.
    function automatic logic operand_hazard(
        input logic [4:0] addr,
        input logic [1:0] tuse,
        input logic       rw_e,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic       rw_m,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = rw_e && a3_e == addr && tnew_e > tuse;
        hit_m = rw_m && a3_m == addr && tnew_m > tuse;
        return (tuse != TUSE_NONE) && (addr != 5'd0) && (hit_e || hit_m);
    endfunction

    // Forwarding and stall decode from the current stage snapshot.
    always_comb begin
        rd1_sel   = fwd_sel(hz.A1_D, hz.regWrite_M, hz.A3_M, hz.Tnew_M,
                            hz.regWrite_W, hz.A3_W);
        rd2_sel   = fwd_sel(hz.A2_D, hz.regWrite_M, hz.A3_M, hz.Tnew_M,
                            hz.regWrite_W, hz.A3_W);
        hazard_rs = operand_hazard(hz.A1_D, hz.Tuse_rs_D, hz.regWrite_E,
                                   hz.A3_E, hz.Tnew_E, hz.regWrite_M,
                                   hz.A3_M, hz.Tnew_M);
        hazard_rt = operand_hazard(hz.A2_D, hz.Tuse_rt_D, hz.regWrite_E,
                                   hz.A3_E, hz.Tnew_E, hz.regWrite_M,
                                   hz.A3_M, hz.Tnew_M);
        mdu_busy  = hz.start_E || (busy_cnt_q != 4'd0);
        stall_raw = (hazard_rs || hazard_rt
                     || (hz.md_D && mdu_busy)
                     || (hz.eret_D && (hz.mtc0_epc_E || hz.mtc0_epc_M)))
                    && !hz.req;
        flush_raw = stall_raw || hz.req;
    end

    // Outputs are forced quiet while reset is held, independent of clk.
    always_comb begin
        hz.RD1_sel = reset ? rd1_sel   : SEL_GRF;
        hz.RD2_sel = reset ? rd2_sel   : SEL_GRF;
        hz.stall   = reset & stall_raw;
        hz.flush_E = reset & flush_raw;
        hz.busy    = reset & mdu_busy;
    end

    // Busy counter next state: exception clears it, a running operation
    // counts down and ignores new starts, an idle unit loads on start.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (hz.req) begin
            busy_cnt_d = 4'd0;
        end else if (busy_cnt_q != 4'd0) begin
            busy_cnt_d = busy_cnt_q - 4'd1;
        end else if (hz.start_E) begin
            busy_cnt_d = hz.div_E ? DIV_CYCLES : MUL_CYCLES;
        end
    end

    // Busy counter register; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_cnt_q <= 4'd0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

`ifdef HAZARD_STALL_STAT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_raw && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Statistics register; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
`else
    assign hz.stall_cnt = 16'd0;
`endif

endmodule
